gascon_perm_arbiter: RTL and testbench

// - Shares one Gascon_Core_Round instance between two requesters: req0 = mix engine, req1 = DryGASCON G-function.
// - Per grant: runs N single-round permutations back-to-back, then returns the permuted state.
// - Instantiated beside the core round in the DrySponge top; replaces per-engine private core copies.

---
 rtl/gascon_pkg.sv | 15 +
 rtl/gascon_rr_arb2.sv | 18 +
 rtl/gascon_perm_arbiter.sv | 149 ++++++++++++++
 tb/tb_gascon_perm_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gascon_pkg.sv
// Shared types and default widths for the Gascon permutation arbiter slice.
// Latency: none (declarations only). Backpressure: n/a.
package gascon_pkg;

   localparam int DEF_CWIDTH = 320;
   localparam int DEF_RCNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      RESP
   } gperm_state_t;

endpackage

// File: rtl/gascon_rr_arb2.sv
// Two-input round-robin pick: rr_ptr selects the favoured requester on a tie.
// Latency: combinational. Backpressure: none.
module gascon_rr_arb2
   import gascon_pkg::*;
(
   input  logic [1:0] req,
   input  logic       rr_ptr,
   output logic [1:0] win
);

   always_comb begin
      win = req;
      if (req == 2'b11) begin
         win = rr_ptr ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/gascon_perm_arbiter.sv
// Shares one Gascon core round between two requesters, running N rounds per grant.
// Latency: 1 + N*(Tcore+1) cycles after req is sampled (2 when N=0); result held until rsp_ready.
// Optional GASPERM_TIMEOUT_EN adds a per-round watchdog that aborts to RESP with err set.
module gascon_perm_arbiter
   import gascon_pkg::*;
#(
   parameter int CWIDTH = DEF_CWIDTH,
   parameter int RCNT_W = DEF_RCNT_W
`ifdef GASPERM_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 64
`endif
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req,
   input  logic [CWIDTH-1:0] req0_c,
   input  logic [CWIDTH-1:0] req1_c,
   input  logic [RCNT_W-1:0] req0_rounds,
   input  logic [RCNT_W-1:0] req1_rounds,
   input  logic [RCNT_W-1:0] req0_rbase,
   input  logic [RCNT_W-1:0] req1_rbase,
   output logic [1:0]        gnt,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [CWIDTH-1:0] rsp_c,
   output logic              err,
   output logic [CWIDTH-1:0] core_c,
   output logic [RCNT_W-1:0] core_round,
   output logic              core_reset,
   input  logic [CWIDTH-1:0] core_cout,
   input  logic              core_done
);

   gperm_state_t      state, state_nxt;
   logic [1:0]        win;
   logic              rr_ptr;
   logic [CWIDTH-1:0] st;
   logic [RCNT_W-1:0] rem;
   logic [RCNT_W-1:0] ridx;
   logic              tmo;

   gascon_rr_arb2 u_arb (
      .req    (req),
      .rr_ptr (rr_ptr),
      .win    (win)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req != 2'b00) state_nxt = LOAD;
         LOAD: state_nxt = (rem == '0) ? RESP : RUN;
         RUN: begin
            if (core_done) begin
               state_nxt = (rem == RCNT_W'(1)) ? RESP : LOAD;
            end else if (tmo) begin
               state_nxt = RESP;
            end
         end
         RESP: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign rsp_valid  = (state == RESP);
   assign rsp_c      = rsp_valid ? st : '0;
   assign core_reset = (state != RUN);
   assign core_c     = st;
   assign core_round = ridx;

   // Requester inputs are captured only on the IDLE->LOAD edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt    <= '0;
         rr_ptr <= 1'b0;
         st     <= '0;
         rem    <= '0;
         ridx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  gnt <= win;
                  if (win[1]) begin
                     st   <= req1_c;
                     rem  <= req1_rounds;
                     ridx <= req1_rbase;
                  end else begin
                     st   <= req0_c;
                     rem  <= req0_rounds;
                     ridx <= req0_rbase;
                  end
               end
            end
            RUN: begin
               if (core_done) begin
                  st   <= core_cout;
                  rem  <= rem - RCNT_W'(1);
                  ridx <= ridx + RCNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rr_ptr <= gnt[0];
                  gnt    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef GASPERM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT);
   logic [TW-1:0] tcnt;

   assign tmo = (state == RUN) && !core_done && (tcnt == TW'(TIMEOUT - 1));

   // Every RUN entry comes from LOAD, so clearing there restarts the watchdog per round.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tcnt <= '0;
         err  <= 1'b0;
      end else begin
         if (state == LOAD) begin
            tcnt <= '0;
         end else if (state == RUN) begin
            tcnt <= tcnt + TW'(1);
         end
         if (tmo) begin
            err <= 1'b1;
         end
      end
   end
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gascon_perm_arbiter.sv
// Self-checking bench: table-driven directed transactions, randomized transactions against a reference model.
module tb_gascon_perm_arbiter;

   localparam int CW = 320;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    req;
   logic [CW-1:0] req0_c, req1_c;
   logic [3:0]    req0_rounds, req1_rounds, req0_rbase, req1_rbase;
   logic [1:0]    gnt;
   logic          rsp_valid, rsp_ready;
   logic [CW-1:0] rsp_c;
   logic          err;
   logic [CW-1:0] core_c;
   logic [3:0]    core_round;
   logic          core_reset;
   logic [CW-1:0] core_cout;
   logic          core_done;

   int checks = 0;
   int errors = 0;
   int tcore = 4;
   bit core_en = 1'b1;
   bit stray = 1'b0;
   bit pref = 1'b0;   // model: 0 favours requester 0 on a tie

   gascon_perm_arbiter dut (
      .clk(clk), .reset(reset), .req(req),
      .req0_c(req0_c), .req1_c(req1_c),
      .req0_rounds(req0_rounds), .req1_rounds(req1_rounds),
      .req0_rbase(req0_rbase), .req1_rbase(req1_rbase),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
      .err(err), .core_c(core_c), .core_round(core_round), .core_reset(core_reset),
      .core_cout(core_cout), .core_done(core_done)
   );

   always #5 clk = ~clk;

   function automatic logic [CW-1:0] perm(input logic [CW-1:0] c, input logic [3:0] r);
      logic [63:0] k;
      k = 64'h9e3779b97f4a7c15 ^ {60'h0, r};
      return {c[CW-8:0], c[CW-1:CW-7]} ^ {5{k}};
   endfunction

   function automatic logic [CW-1:0] rnd320();
      logic [CW-1:0] v;
      for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   // Core round model: loads while core_reset is high, done in the tcore-th running cycle.
   logic [CW-1:0] lat_c;
   logic [3:0]    lat_r;
   int            ccnt;
   always @(posedge clk) begin
      if (core_reset) begin
         lat_c <= core_c;
         lat_r <= core_round;
         ccnt  <= 0;
      end else begin
         ccnt <= ccnt + 1;
      end
   end
   assign core_done = (core_en && !core_reset && ccnt == tcore - 1) || stray;
   assign core_cout = perm(lat_c, lat_r);

   task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Called at a negedge with the DUT in IDLE. Counts posedges from req being applied until rsp_valid.
   task automatic run_txn(input logic [1:0] r, input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                          input logic [3:0] n0, input logic [3:0] b0, input logic [3:0] n1, input logic [3:0] b1,
                          input logic [1:0] exp_g, input int exp_lat, input int hold, input bit scramble);
      logic [CW-1:0] exp_c, hold_c;
      logic [3:0]    n, rb;
      logic [3:0]    eseq[$];
      logic [3:0]    rseq[$];
      int            lat, runs;
      bit            got;
      n     = exp_g[1] ? n1 : n0;
      rb    = exp_g[1] ? b1 : b0;
      exp_c = exp_g[1] ? c1 : c0;
      for (int k = 0; k < int'(n); k++) begin
         eseq.push_back(rb + 4'(k));
         exp_c = perm(exp_c, rb + 4'(k));
      end
      req = r; req0_c = c0; req1_c = c1;
      req0_rounds = n0; req0_rbase = b0; req1_rounds = n1; req1_rbase = b1;
      rsp_ready = (hold == 0);
      lat = 0; runs = 0; got = 1'b0;
      while (!got && lat < 1000) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (scramble && lat == 1) begin
            req0_c = rnd320(); req1_c = rnd320();
            req0_rounds = 4'($urandom()); req1_rounds = 4'($urandom());
            req0_rbase = 4'($urandom()); req1_rbase = 4'($urandom());
            req = r & 2'($urandom());
         end
         if (!core_reset) runs++;
         if (core_done && !core_reset) rseq.push_back(core_round);
         if (rsp_valid) got = 1'b1;
      end
      chk("rsp_valid_seen", CW'(got), CW'(1));
      chk("gnt", CW'(gnt), CW'(exp_g));
      chk("latency", CW'(lat), CW'(exp_lat));
      chk("rsp_c", rsp_c, exp_c);
      chk("err_clear", CW'(err), CW'(0));
      chk("run_cycles", CW'(runs), CW'(int'(n) * tcore));
      chk("round_count", CW'(rseq.size()), CW'(eseq.size()));
      for (int i = 0; i < eseq.size() && i < rseq.size(); i++) chk("core_round_seq", CW'(rseq[i]), CW'(eseq[i]));
      if (hold > 0) begin
         hold_c = exp_c;
         req = 2'b11;
         for (int h = 0; h < hold; h++) begin
            stray = (h == 3);
            @(posedge clk);
            @(negedge clk);
            stray = 1'b0;
            chk("hold_valid", CW'(rsp_valid), CW'(1));
            chk("hold_rsp_c", rsp_c, hold_c);
            chk("hold_gnt", CW'(gnt), CW'(exp_g));
         end
         rsp_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      chk("post_valid", CW'(rsp_valid), CW'(0));
      chk("post_gnt", CW'(gnt), CW'(0));
      chk("post_rsp_c", rsp_c, CW'(0));
   endtask

   typedef struct {
      logic [1:0] req;
      logic [3:0] n0, b0, n1, b1;
      logic [1:0] gnt;
      int         lat;
      int         hold;
   } vec_t;

   initial begin
      vec_t tbl[6];
      logic [1:0] r, eg;
      logic [3:0] n0, b0, n1, b1, n;
      logic [CW-1:0] c0;

      // Latency with tcore=4: N=0 -> 2, else 1 + N*5 (req applied in cycle 1, RESP in cycle 2+N*5).
      tbl[0] = '{2'b11, 4'd1, 4'd2,  4'd1, 4'd9, 2'b01,  6, 0};
      tbl[1] = '{2'b11, 4'd1, 4'd2,  4'd1, 4'd9, 2'b10,  6, 0};
      tbl[2] = '{2'b01, 4'd3, 4'd5,  4'd0, 4'd0, 2'b01, 16, 0};
      tbl[3] = '{2'b10, 4'd0, 4'd0,  4'd0, 4'd7, 2'b10,  2, 0};
      tbl[4] = '{2'b01, 4'd2, 4'd15, 4'd0, 4'd0, 2'b01, 11, 10};
      tbl[5] = '{2'b11, 4'd0, 4'd0,  4'd2, 4'd1, 2'b10, 11, 0};

      reset = 1'b0; req = 2'b00; rsp_ready = 1'b0;
      req0_c = '0; req1_c = '0; req0_rounds = '0; req1_rounds = '0; req0_rbase = '0; req1_rbase = '0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", CW'(gnt), CW'(0));
      chk("rst_rsp_valid", CW'(rsp_valid), CW'(0));
      chk("rst_rsp_c", rsp_c, CW'(0));
      chk("rst_err", CW'(err), CW'(0));
      chk("rst_core_reset", CW'(core_reset), CW'(1));
      chk("rst_core_c", core_c, CW'(0));
      chk("rst_core_round", CW'(core_round), CW'(0));
      reset = 1'b1;
      @(negedge clk);

      tcore = 4;
      for (int i = 0; i < 6; i++) begin
         run_txn(tbl[i].req, rnd320(), rnd320(), tbl[i].n0, tbl[i].b0, tbl[i].n1, tbl[i].b1,
                 tbl[i].gnt, tbl[i].lat, tbl[i].hold, 1'b0);
      end
      pref = 1'b0;

      for (int i = 0; i < 24; i++) begin
         r  = 2'($urandom_range(1, 3));
         n0 = 4'($urandom_range(0, 4)); n1 = 4'($urandom_range(0, 4));
         b0 = 4'($urandom()); b1 = 4'($urandom());
         tcore = $urandom_range(1, 6);
         if (r == 2'b11) eg = pref ? 2'b10 : 2'b01;
         else eg = r;
         n = eg[1] ? n1 : n0;
         run_txn(r, rnd320(), rnd320(), n0, b0, n1, b1, eg,
                 1 + ((n == 0) ? 1 : int'(n) * (tcore + 1)), 0, 1'b1);
         pref = eg[0];
      end

      // Reset in the middle of RUN.
      tcore = 4;
      req = 2'b01; req0_rounds = 4'd3; req0_rbase = 4'd0; req0_c = rnd320(); rsp_ready = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("mid_in_run", CW'(core_reset), CW'(0));
      reset = 1'b0;
      #1;
      chk("mid_rst_gnt", CW'(gnt), CW'(0));
      chk("mid_rst_valid", CW'(rsp_valid), CW'(0));
      @(negedge clk);
      req = 2'b00;
      chk("mid_rst_core_c", core_c, CW'(0));
      chk("mid_rst_core_reset", CW'(core_reset), CW'(1));
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("mid_rst_no_rsp", CW'(rsp_valid), CW'(0));
      end
      run_txn(2'b11, rnd320(), rnd320(), 4'd1, 4'd3, 4'd1, 4'd4, 2'b01, 6, 0, 1'b0);

`ifdef GASPERM_TIMEOUT_EN
      begin
         int lat;
         core_en = 1'b0;
         c0 = rnd320();
         req = 2'b01; req0_c = c0; req0_rounds = 4'd2; req0_rbase = 4'd3; rsp_ready = 1'b1;
         lat = 0;
         while (!rsp_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
         end
         chk("tmo_latency", CW'(lat), CW'(66));
         chk("tmo_err", CW'(err), CW'(1));
         chk("tmo_rsp_c", rsp_c, c0);
         req = 2'b00;
         @(negedge clk);
         chk("tmo_err_sticky", CW'(err), CW'(1));
         reset = 1'b0;
         @(negedge clk);
         chk("tmo_err_cleared", CW'(err), CW'(0));
         reset = 1'b1;
         core_en = 1'b1;
      end
`endif

      req = 2'b00;
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
